// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (2'b11 is illegal and behaves as a word)
//   - FSM state type
//   - default bus timeout
//   - lsu_crosses(): does an access of a given size/offset spill into the next word
package lsu_pkg;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam int unsigned DefaultBusTimeout = 255;

  typedef enum logic [1:0] {
    StIdle,
    StBeat0,
    StBeat1,
    StFin
  } lsu_state_e;

  function automatic logic lsu_crosses(input logic [1:0] size, input logic [1:0] off);
    logic c;
    case (size)
      SizeByte: c = 1'b0;
      SizeHalf: c = (off == 2'd3);
      default:  c = (off != 2'd0);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   size_i, offset_i   access size and byte offset within the word
//   wdata_i            store data (unshifted)
//   is_unsigned_i      zero-extend load result
//   rdata_lo_i/hi_i    read data of first/second word (hi only matters when crossing)
//   be0_o/be1_o        byte enables for the first/second beat
//   wdata0_o/wdata1_o  shifted store data for the first/second beat
//   crosses_o          access spills past lane 3
//   load_data_o        extracted and extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic        is_unsigned_i,
  input  logic [31:0] rdata_lo_i,
  input  logic [31:0] rdata_hi_i,
  output logic [3:0]  be0_o,
  output logic [3:0]  be1_o,
  output logic [31:0] wdata0_o,
  output logic [31:0] wdata1_o,
  output logic        crosses_o,
  output logic [31:0] load_data_o
);

  logic [3:0]  mask;
  logic [4:0]  shamt;
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic [31:0] rdata_sh;

  assign shamt = {offset_i, 3'b000};

  always_comb begin
    mask = 4'b1111;
    unique case (size_i)
      SizeByte:        mask = 4'b0001;
      SizeHalf:        mask = 4'b0011;
      SizeWord, 2'b11: mask = 4'b1111;
    endcase
  end

  // Treat the two beats as one 64-bit window; the upper half is what spills into beat 1.
  assign be_wide    = {4'b0000, mask} << offset_i;
  assign wdata_wide = {32'h0, wdata_i} << shamt;
  assign be0_o      = be_wide[3:0];
  assign be1_o      = be_wide[7:4];
  assign wdata0_o   = wdata_wide[31:0];
  assign wdata1_o   = wdata_wide[63:32];
  assign crosses_o  = lsu_crosses(size_i, offset_i);

  assign rdata_sh = 32'({rdata_hi_i, rdata_lo_i} >> shamt);

  always_comb begin
    load_data_o = rdata_sh;
    unique case (size_i)
      SizeByte: load_data_o = is_unsigned_i ? {24'h0, rdata_sh[7:0]}
                                            : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      SizeHalf: load_data_o = is_unsigned_i ? {16'h0, rdata_sh[15:0]}
                                            : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      SizeWord, 2'b11: load_data_o = rdata_sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns one load/store instruction into one or two word-aligned bus beats.
//   clk, rst (async, active-high)
//   req_*      instruction request, held until done
//   stall      hold PC / register-file write while the access is in flight
//   done, err, load_data   one-cycle completion pulse, error pulse, extended load result
//   bus_*      simple valid/ready word bus with byte enables
// Build option: LSU_MISALIGNED_EN -- when defined, word-crossing accesses are split into two
// beats; otherwise they are refused with err and no bus traffic.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = DefaultBusTimeout
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = $clog2(BUS_TIMEOUT + 1);

  lsu_state_e      state_q, state_d;
  logic            store_q, store_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata0_q, rdata0_d;
  logic            abort_q, abort_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [31:0]     load_data_q, load_data_d;

  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1, ld_ext, rdata_lo, word_addr;
  logic        crosses, in_beat, abort_now;

  // In beat 1 the low word was captured at the end of beat 0.
  assign rdata_lo = (state_q == StBeat1) ? rdata0_q : bus_rdata;

  lsu_align u_align (
    .size_i        (size_q),
    .offset_i      (addr_q[1:0]),
    .wdata_i       (wdata_q),
    .is_unsigned_i (uns_q),
    .rdata_lo_i    (rdata_lo),
    .rdata_hi_i    (bus_rdata),
    .be0_o         (be0),
    .be1_o         (be1),
    .wdata0_o      (wdata0),
    .wdata1_o      (wdata1),
    .crosses_o     (crosses),
    .load_data_o   (ld_ext)
  );

  assign in_beat   = (state_q == StBeat0) || (state_q == StBeat1);
  assign word_addr = {addr_q[31:2], 2'b00};
  assign abort_now = abort_q | ~req_valid;

  // Bus outputs depend only on flops, so they hold steady through wait states.
  always_comb begin
    bus_valid = in_beat;
    bus_we    = in_beat & store_q;
    bus_addr  = 32'h0;
    bus_be    = 4'h0;
    bus_wdata = 32'h0;
    if (state_q == StBeat0) begin
      bus_addr  = word_addr;
      bus_be    = be0;
      bus_wdata = wdata0;
    end else if (state_q == StBeat1) begin
      bus_addr  = word_addr + 32'd4;  // wraps at the top of the address space
      bus_be    = be1;
      bus_wdata = wdata1;
    end
  end

  assign stall     = req_valid & (state_q != StFin) & ~rst;
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = load_data_q;

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    abort_d     = abort_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load_data_d = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          abort_d = 1'b0;
          cnt_d   = '0;
`ifdef LSU_MISALIGNED_EN
          state_d = StBeat0;
`else
          // Crossing access is refused without touching the bus.
          if (lsu_crosses(req_size, req_addr[1:0])) begin
            state_d = StFin;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = StBeat0;
          end
`endif
        end
      end
      StBeat0, StBeat1: begin
        // A dropped request still finishes its bus traffic, only done is withheld.
        if (!req_valid) abort_d = 1'b1;
        if (bus_ready) begin
          cnt_d = '0;
          if (state_q == StBeat0 && crosses) begin
            state_d  = StBeat1;
            rdata0_d = bus_rdata;
          end else begin
            state_d     = StFin;
            done_d      = ~abort_now;
            load_data_d = store_q ? 32'h0 : ld_ext;
          end
        end else if (cnt_q == CntW'(BUS_TIMEOUT - 1)) begin
          state_d = StFin;
          done_d  = ~abort_now;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      store_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rdata0_q    <= 32'h0;
      abort_q     <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      abort_q     <= abort_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

endmodule
